// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   state_t          : arbiter FSM state (IDLE, GRANT)
//   depth_len()      : requester-index width for a given requester count
//   MAX_HOLD_DEFAULT : default grant timeout in cycles
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned MAX_HOLD_DEFAULT = 16;

  // Index width; never narrower than one bit.
  function automatic int unsigned depth_len(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Priority encoder: reports the index of the lowest set bit ("first 1").
//   data        : input vector
//   first_pos_c : index of the lowest set bit (0 when data is zero)
//   found_c     : data has at least one bit set
module priority_encoder #(
  parameter int unsigned DATA_LEN  = 8,
  parameter int unsigned DEPTH_LEN = 3
) (
  input  logic [DATA_LEN-1:0]  data,
  output logic [DEPTH_LEN-1:0] first_pos_c,
  output logic                 found_c
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    first_pos_c = '0;
    for (int i = DATA_LEN - 1; i >= 0; i--) begin
      if (data[i]) first_pos_c = DEPTH_LEN'(i);
    end
  end

  assign found_c = |data;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter sharing one downstream resource between DATA_LEN
// requesters. A grant is held until done, then priority rotates to the
// requester just above the last owner; re-arbitration on release is
// back-to-back.
// Optional feature: define GRANT_TIMEOUT_EN to revoke a grant after
// MAX_HOLD cycles without done (timeout pulses for one cycle).
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector, bit i = requester i wants the resource
//   done       : resource finished the current owner's transaction
//   gnt_valid  : a grant is active
//   gnt_id     : index of the current owner (datapath mux select)
//   gnt_onehot : one-hot grant, zero when no grant is active
//   timeout    : one-cycle pulse when the timer revokes a grant
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned DATA_LEN  = 8,
  parameter int unsigned DEPTH_LEN = depth_len(DATA_LEN)
`ifdef GRANT_TIMEOUT_EN
  ,
  parameter int unsigned MAX_HOLD  = MAX_HOLD_DEFAULT
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_LEN-1:0]  req,
  input  logic                 done,
  output logic                 gnt_valid,
  output logic [DEPTH_LEN-1:0] gnt_id,
  output logic [DATA_LEN-1:0]  gnt_onehot,
  output logic                 timeout
);

  state_t               state;
  logic [DEPTH_LEN-1:0] ptr;
  logic [DEPTH_LEN-1:0] base_c;
  logic [DATA_LEN-1:0]  masked_c;
  logic [DATA_LEN-1:0]  sel_c;
  logic [DEPTH_LEN-1:0] win_c;
  logic                 win_valid_c;
  logic                 release_c;

  // Priority base: in GRANT the only use is re-arbitration on release, which
  // must already see the rotated pointer (owner + 1, wrapping naturally).
  always_comb begin
    base_c   = (state == GRANT) ? (gnt_id + DEPTH_LEN'(1)) : ptr;
    masked_c = req & ~((DATA_LEN'(1) << base_c) - DATA_LEN'(1));
    sel_c    = (masked_c != '0) ? masked_c : req;
  end

  priority_encoder #(
    .DATA_LEN  (DATA_LEN),
    .DEPTH_LEN (DEPTH_LEN)
  ) u_penc (
    .data        (sel_c),
    .first_pos_c (win_c),
    .found_c     (win_valid_c)
  );

`ifdef GRANT_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;

  logic [HOLD_W-1:0] hold_cnt;
  logic              expire_c;

  // Expiry on the MAX_HOLD-th grant cycle; done in the same cycle wins.
  assign expire_c  = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign release_c = (state == GRANT) && (done || expire_c);
`else
  assign release_c = (state == GRANT) && done;
  assign timeout   = 1'b0;
`endif

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_valid  <= 1'b0;
      gnt_id     <= '0;
      gnt_onehot <= '0;
`ifdef GRANT_TIMEOUT_EN
      hold_cnt   <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
`ifdef GRANT_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_valid_c) begin
            state      <= GRANT;
            gnt_valid  <= 1'b1;
            gnt_id     <= win_c;
            gnt_onehot <= DATA_LEN'(1) << win_c;
`ifdef GRANT_TIMEOUT_EN
            hold_cnt   <= '0;
`endif
          end
        end
        GRANT: begin
          if (release_c) begin
            ptr <= gnt_id + DEPTH_LEN'(1);
`ifdef GRANT_TIMEOUT_EN
            timeout <= expire_c && !done;
`endif
            if (win_valid_c) begin
              gnt_id     <= win_c;
              gnt_onehot <= DATA_LEN'(1) << win_c;
`ifdef GRANT_TIMEOUT_EN
              hold_cnt   <= '0;
`endif
            end else begin
              state      <= IDLE;
              gnt_valid  <= 1'b0;
              gnt_onehot <= '0;
            end
          end else begin
`ifdef GRANT_TIMEOUT_EN
            hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: a rule-level reference model checked every cycle,
// plus hand-computed grant sequences. Honours GRANT_TIMEOUT_EN (MAX_HOLD=4).
module tb_rr_arbiter;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;
`ifdef GRANT_TIMEOUT_EN
  localparam int unsigned HOLD   = 4;
  localparam bit          TO_EN  = 1'b1;
`else
  localparam int unsigned HOLD   = 0;
  localparam bit          TO_EN  = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic         done  = 1'b0;
  logic         gnt_valid;
  logic [W-1:0] gnt_id;
  logic [N-1:0] gnt_onehot;
  logic         timeout;

  always #5 clk = ~clk;

  rr_arbiter #(
    .DATA_LEN (N)
`ifdef GRANT_TIMEOUT_EN
    ,
    .MAX_HOLD (HOLD)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requester scanning upward from p, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference model state.
  bit m_valid;
  bit m_to;
  int m_id;
  int m_ptr;
  int m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_to = 1'b0; m_id = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      m_to = 1'b0;
      if (!m_valid) begin
        if (req != '0) begin
          m_id = pick(req, m_ptr); m_valid = 1'b1; m_cnt = 0;
        end
      end else begin
        bit expired;
        expired = TO_EN && (m_cnt == int'(HOLD) - 1);
        if (done || expired) begin
          m_to  = expired && !done;
          m_ptr = (m_id + 1) % N;
          if (req != '0) begin
            m_id = pick(req, m_ptr); m_cnt = 0;
          end else begin
            m_valid = 1'b0;
          end
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("valid", 32'(gnt_valid), 32'(m_valid));
    check("onehot", 32'(gnt_onehot), m_valid ? (32'd1 << m_id) : 32'd0);
    if (m_valid) check("id", 32'(gnt_id), 32'(m_id));
    check("timeout", 32'(timeout), 32'(m_to));
  end

  // Apply inputs for one clock edge; returns at the following falling edge.
  task automatic step(input logic [N-1:0] r, input logic d);
    req  = r;
    done = d;
    @(negedge clk);
  endtask

  task automatic expect_grant(input string name, input int id);
    check({name, "_valid"}, 32'(gnt_valid), 32'd1);
    check({name, "_id"}, 32'(gnt_id), 32'(id));
    check({name, "_onehot"}, 32'(gnt_onehot), 32'd1 << id);
  endtask

  task automatic expect_idle(input string name);
    check({name, "_valid"}, 32'(gnt_valid), 32'd0);
    check({name, "_onehot"}, 32'(gnt_onehot), 32'd0);
  endtask

  task automatic do_reset();
    req = '0; done = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [N-1:0] pats [4] = '{8'hA5, 8'h5A, 8'hFF, 8'h81};
  int           seq  [5] = '{0, 3, 7, 0, 3};

  initial begin
    // Reset and idle.
    repeat (2) @(negedge clk);
    expect_idle("reset");
    check("reset_id", 32'(gnt_id), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step('0, 1'b0);
      expect_idle("idle");
    end

    // Single request, then release to idle (ptr -> 3).
    step(8'h04, 1'b0);
    expect_grant("single", 2);
    step('0, 1'b1);
    expect_idle("single_rel");
    step('0, 1'b1);
    expect_idle("done_in_idle");
    // With ptr=3, requesters 0 and 3 pick 3.
    step(8'h09, 1'b0);
    expect_grant("ptr3", 3);
    step('0, 1'b1);
    expect_idle("ptr3_rel");

    // Rotation from ptr=0.
    do_reset();
    step(8'h89, 1'b0);
    expect_grant("rot0", seq[0]);
    for (int i = 1; i < 5; i++) begin
      step(8'h89, 1'b1);
      expect_grant("rot", seq[i]);
    end
    step('0, 1'b1);
    expect_idle("rot_rel");

    // Wrap: owner 4 releases (ptr 5), only 0 and 1 request.
    step(8'h10, 1'b0);
    expect_grant("own4", 4);
    step(8'h03, 1'b1);
    expect_grant("wrap0", 0);
    step(8'h03, 1'b1);
    expect_grant("wrap1", 1);
    step('0, 1'b1);
    expect_idle("wrap_rel");

    // Hold: owner 3 drops its request, grant stays.
    step(8'h08, 1'b0);
    expect_grant("hold", 3);
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b0);
`ifndef GRANT_TIMEOUT_EN
      expect_grant("hold_dropped", 3);
`endif
    end
    step(8'h40, 1'b0);
    // Asynchronous reset mid-cycle drops the grant immediately.
    req = 8'h40;
    #2 rst_n = 1'b0;
    #1;
    expect_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hFF, 1'b0);
    expect_grant("after_rst", 0);
    step('0, 1'b1);

    // Mixed patterns, one done per grant; model checks every cycle.
    foreach (pats[i]) begin
      step(pats[i], 1'b0);
      step(pats[i], 1'b1);
      step(pats[i], 1'b1);
    end
    step('0, 1'b1);
    expect_idle("pats_rel");

`ifdef GRANT_TIMEOUT_EN
    // Timeout: grant 1 revoked after 4 cycles, passes to 2.
    do_reset();
    step(8'h06, 1'b0);
    expect_grant("to_g1", 1);
    for (int i = 0; i < 3; i++) begin
      step(8'h06, 1'b0);
      expect_grant("to_hold", 1);
      check("to_quiet", 32'(timeout), 32'd0);
    end
    step(8'h06, 1'b0);
    expect_grant("to_next", 2);
    check("to_pulse", 32'(timeout), 32'd1);
    step(8'h06, 1'b0);
    check("to_pulse_end", 32'(timeout), 32'd0);
    step(8'h06, 1'b0);
    step(8'h06, 1'b0);
    // done coincides with expiry: no timeout pulse, rotation wraps to 1.
    step(8'h06, 1'b1);
    expect_grant("to_done", 1);
    check("to_done_quiet", 32'(timeout), 32'd0);
    step('0, 1'b1);
    expect_idle("to_rel");
`endif

    req = '0; done = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource between DATA_LEN requesters.
- Uses a priority_encoder instance (lowest set bit index = "first 1") on a pointer-masked request vector to pick the next owner.
- Holds the grant until the resource signals completion, then rotates priority past the last owner.
- Sits between the requester bank and the shared datapath; gnt_id drives the datapath's input mux select.

Parameters:
- DATA_LEN, 8, number of requesters; power of two, at least 2.
- DEPTH_LEN, $clog2(DATA_LEN), width of the requester index.
- MAX_HOLD, 16, grant timeout in cycles; used only when GRANT_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  DATA_LEN  request vector; bit i means requester i wants the resource.
- done  input  1  resource finished the current owner's transaction; meaningful only while gnt_valid=1.
- gnt_valid  output  1  a grant is active.
- gnt_id  output  DEPTH_LEN  index of the current owner.
- gnt_onehot  output  DATA_LEN  one-hot grant; equals 1<<gnt_id when gnt_valid=1, else 0.
- timeout  output  1  one-cycle pulse when a grant is revoked by the timer; tied to 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous, rst_n=0): gnt_valid=0, gnt_id=0, gnt_onehot=0, timeout=0, ptr=0, hold_cnt=0, FSM=IDLE.
- Selection (combinational):
  - masked = req & ~((1<<ptr)-1).
  - If masked != 0, winner = first_1_pos(masked); else winner = first_1_pos(req).
  - req=0 means no winner.
- FSM states:
  - IDLE: if req != 0 at edge t, then from t+1: GRANT, gnt_valid=1, gnt_id=winner. Latency is one cycle from request to grant.
  - GRANT: outputs hold stable. Changes to req are ignored, including the owner dropping its own request. The state is left only on done=1 (or on timeout).
- Release on done=1 in GRANT:
  - ptr <= (gnt_id+1) mod DATA_LEN; wraps from DATA_LEN-1 to 0.
  - Re-arbitration uses the new ptr and the current req.
  - If a winner exists, it is granted in the next cycle (back-to-back, no idle gap); the same requester may win again if it is the only one requesting.
  - Otherwise go to IDLE with gnt_valid=0.
- done=1 in IDLE is ignored.
- Simultaneous requests: the winner is the lowest index at or above ptr; otherwise wrap to the lowest index overall. Starvation-free: any requester that holds req is granted within DATA_LEN-1 other grants.
- ptr updates only on release, never on grant.
- rst_n asserted mid-grant: the grant drops immediately (asynchronous) and ptr returns to 0.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - hold_cnt counts GRANT cycles.
  - When hold_cnt reaches MAX_HOLD-1 without done, the grant is released exactly as on done, and timeout pulses high for 1 cycle.
  - hold_cnt clears on every new grant.
  - done and expiry in the same cycle: treated as done, no timeout pulse.
- Not defined: no counter is present, timeout=0, and a grant is held indefinitely.

Decomposition:
- Shared package arb_pkg holds:
  - state typedef (IDLE, GRANT);
  - DEPTH_LEN derivation function;
  - default MAX_HOLD constant.
- One natural sub-module: the existing priority_encoder, instantiated once on the selected vector (masked if nonzero, else req). It is not duplicated.

Test Plan:
- Reset/idle: rst_n=0 then 1, req=0 for 5 cycles -> gnt_valid=0, gnt_onehot=0 throughout.
- Single request: req=8'b0000_0100 -> next cycle gnt_id=2, gnt_onehot=8'b0000_0100. Then done=1 with req=0 -> gnt_valid=0 one cycle later, ptr=3.
- Rotation: ptr=0, req=8'b1000_1001 held, done pulsed after each grant -> gnt_id sequence 0,3,7,0,3.
- Wrap: ptr=5 after owner 4 releases, req=8'b0000_0011 -> gnt_id=0 (masked empty, wrap). Next release -> gnt_id=1.
- Hold and reset mid-grant: owner 3 drops req while granted -> gnt_id stays 3 until done. Then rst_n=0 mid-grant -> gnt_valid=0 immediately; after reset release, req=8'hFF -> gnt_id=0.
- GRANT_TIMEOUT_EN with MAX_HOLD=4: grant to 1, no done -> revoked after 4 cycles, timeout=1 for one cycle, next grant goes to the next requester above 1.
